// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX latch, MEM/WB operand forwarding, load-use hazard and stall counter
module ex_operand_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_aluop,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [WORD_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  logic              id_shift,
    input  logic [4:0]        id_shamt,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              id_regwen,
    input  logic              id_memread,
    input  logic              mem_regwen,
    input  logic [REG_W-1:0]  mem_wsel,
    input  logic [WORD_W-1:0] mem_wdat,
    input  logic              wb_regwen,
    input  logic [REG_W-1:0]  wb_wsel,
    input  logic [WORD_W-1:0] wb_wdat,
    input  logic              ex_stall,
    input  logic              flush,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_aluop,
    output logic              ex_valid,
    output logic              ex_regwen,
    output logic              ex_memread,
    output logic [REG_W-1:0]  ex_wsel,
    output logic [WORD_W-1:0] ex_store_dat,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [OP_W-1:0] ALU_SLL = '0;

    logic              valid_q;
    logic              regwen_q;
    logic              memread_q;
    logic [OP_W-1:0]   aluop_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [WORD_W-1:0] rdat1_q;
    logic [WORD_W-1:0] rdat2_q;
    logic [WORD_W-1:0] imm_q;
    logic              alusrc_q;
    logic              shift_q;
    logic [4:0]        shamt_q;
    logic [REG_W-1:0]  wsel_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [WORD_W-1:0] fwd_rs;
    logic [WORD_W-1:0] fwd_rt;

    // Operand bypass: MEM beats WB, register 0 always reads the latched value
    always_comb begin
        fwd_rs = rdat1_q;
        if (mem_regwen && (mem_wsel == rs_q) && (rs_q != '0))
            fwd_rs = mem_wdat;
        else if (wb_regwen && (wb_wsel == rs_q) && (rs_q != '0))
            fwd_rs = wb_wdat;

        fwd_rt = rdat2_q;
        if (mem_regwen && (mem_wsel == rt_q) && (rt_q != '0))
            fwd_rt = mem_wdat;
        else if (wb_regwen && (wb_wsel == rt_q) && (rt_q != '0))
            fwd_rt = wb_wdat;
    end

    // Operand muxing and control outputs; control is masked when the slot is empty
    always_comb begin
        alu_a        = shift_q ? {{(WORD_W-5){1'b0}}, shamt_q} : fwd_rs;
        alu_b        = alusrc_q ? imm_q : fwd_rt;
        ex_store_dat = fwd_rt;
        alu_aluop    = aluop_q;
        ex_valid     = valid_q;
        ex_regwen    = valid_q & regwen_q;
        ex_memread   = valid_q & memread_q;
        ex_wsel      = wsel_q;
        stall_count  = cnt_q;
    end

    // Load in EX whose result the instruction in ID needs; flush cancels the request
    always_comb begin
        hazard_stall = ex_valid & ex_memread & (ex_wsel != '0) & id_valid &
                       ((id_rs == ex_wsel) | (id_uses_rt & (id_rt == ex_wsel))) &
                       ~flush;
    end

    // ID/EX latch: flush, then hold (refreshing read data), then bubble, then capture
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q   <= 1'b0;
            regwen_q  <= 1'b0;
            memread_q <= 1'b0;
            aluop_q   <= ALU_SLL;
            rs_q      <= '0;
            rt_q      <= '0;
            rdat1_q   <= '0;
            rdat2_q   <= '0;
            imm_q     <= '0;
            alusrc_q  <= 1'b0;
            shift_q   <= 1'b0;
            shamt_q   <= '0;
            wsel_q    <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            regwen_q  <= 1'b0;
            memread_q <= 1'b0;
        end else if (ex_stall) begin
            rdat1_q   <= fwd_rs;
            rdat2_q   <= fwd_rt;
        end else if (hazard_stall) begin
            valid_q   <= 1'b0;
            regwen_q  <= 1'b0;
            memread_q <= 1'b0;
        end else begin
            valid_q   <= id_valid;
            regwen_q  <= id_regwen;
            memread_q <= id_memread;
            aluop_q   <= id_aluop;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rdat1_q   <= id_rdat1;
            rdat2_q   <= id_rdat2;
            imm_q     <= id_imm;
            alusrc_q  <= id_alusrc;
            shift_q   <= id_shift;
            shamt_q   <= id_shamt;
            wsel_q    <= id_wsel;
        end
    end

    // Saturating count of cycles in which a bubble is actually inserted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt_q <= '0;
        else if (hazard_stall && !ex_stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed-vector bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        id_valid;
    logic [3:0]  id_aluop;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rt;
    logic [31:0] id_rdat1, id_rdat2, id_imm;
    logic        id_alusrc, id_shift;
    logic [4:0]  id_shamt, id_wsel;
    logic        id_regwen, id_memread;
    logic        mem_regwen;
    logic [4:0]  mem_wsel;
    logic [31:0] mem_wdat;
    logic        wb_regwen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        ex_stall, flush;
    logic [31:0] alu_a, alu_b, ex_store_dat;
    logic [3:0]  alu_aluop;
    logic        ex_valid, ex_regwen, ex_memread, hazard_stall;
    logic [4:0]  ex_wsel;
    logic [1:0]  stall_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    ex_operand_stage #(.WORD_W(32), .REG_W(5), .OP_W(4), .CNT_W(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_shift(id_shift),
        .id_shamt(id_shamt), .id_wsel(id_wsel), .id_regwen(id_regwen),
        .id_memread(id_memread),
        .mem_regwen(mem_regwen), .mem_wsel(mem_wsel), .mem_wdat(mem_wdat),
        .wb_regwen(wb_regwen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .ex_stall(ex_stall), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop),
        .ex_valid(ex_valid), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .ex_wsel(ex_wsel), .ex_store_dat(ex_store_dat),
        .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_id();
        id_valid = 0; id_aluop = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_rdat1 = 0; id_rdat2 = 0; id_imm = 0; id_alusrc = 0; id_shift = 0;
        id_shamt = 0; id_wsel = 0; id_regwen = 0; id_memread = 0;
    endtask

    task automatic clr_fwd();
        mem_regwen = 0; mem_wsel = 0; mem_wdat = 0;
        wb_regwen = 0; wb_wsel = 0; wb_wdat = 0;
    endtask

    // lw r<dst>, then an add that reads r<dst> through rt
    task automatic load_use(input logic [4:0] dst);
        clr_id();
        id_valid = 1; id_memread = 1; id_regwen = 1; id_wsel = dst; id_rs = 1;
        tick();
        clr_id();
        id_valid = 1; id_rs = 2; id_rt = dst; id_uses_rt = 1; id_regwen = 1; id_wsel = 10;
        tick();
        tick();
        clr_id();
    endtask

    initial begin
        nRST = 0; ex_stall = 0; flush = 0;
        clr_id(); clr_fwd();
        #3;
        check("rst_valid", ex_valid, 0);
        check("rst_count", stall_count, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_aluop", alu_aluop, 0);
        check("rst_hazard", hazard_stall, 0);
        @(negedge CLK);
        nRST = 1;

        // plain capture of register operands
        id_valid = 1; id_aluop = 3; id_rs = 1; id_rt = 2; id_uses_rt = 1;
        id_rdat1 = 32'h11; id_rdat2 = 32'h22; id_wsel = 3; id_regwen = 1;
        tick();
        check("cap_valid", ex_valid, 1);
        check("cap_a", alu_a, 32'h11);
        check("cap_b", alu_b, 32'h22);
        check("cap_aluop", alu_aluop, 3);
        check("cap_wsel", ex_wsel, 3);
        check("cap_regwen", ex_regwen, 1);

        // shamt and immediate selection, store data stays the rt value
        id_alusrc = 1; id_imm = 32'h100; id_shift = 1; id_shamt = 7;
        tick();
        check("imm_a", alu_a, 7);
        check("imm_b", alu_b, 32'h100);
        check("imm_store", ex_store_dat, 32'h22);

        // invalid slot masks control
        clr_id(); id_regwen = 1; id_memread = 1;
        tick();
        check("inv_regwen", ex_regwen, 0);
        check("inv_memread", ex_memread, 0);

        // forwarding priority on rs=5
        clr_id(); id_valid = 1; id_rs = 5; id_rdat1 = 32'h55;
        tick();
        clr_id();
        mem_regwen = 1; mem_wsel = 5; mem_wdat = 32'hAAAA0000;
        wb_regwen = 1; wb_wsel = 5; wb_wdat = 32'h1234;
        #1 check("fwd_mem", alu_a, 32'hAAAA0000);
        mem_regwen = 0;
        #1 check("fwd_wb", alu_a, 32'h1234);
        wb_regwen = 0;
        #1 check("fwd_none", alu_a, 32'h55);

        // register 0 is never forwarded; rt forwarded from WB
        id_valid = 1; id_rs = 0; id_rt = 4; id_rdat2 = 32'h44;
        tick();
        clr_id();
        mem_regwen = 1; mem_wsel = 0; mem_wdat = 32'hFFFFFFFF;
        wb_regwen = 1; wb_wsel = 4; wb_wdat = 32'hBEEF;
        #1 check("zero_reg", alu_a, 0);
        check("fwd_rt_wb", alu_b, 32'hBEEF);
        check("fwd_rt_store", ex_store_dat, 32'hBEEF);
        clr_fwd();

        // load-use hazard
        id_valid = 1; id_memread = 1; id_regwen = 1; id_wsel = 8; id_rs = 1;
        tick();
        clr_id();
        id_valid = 1; id_rs = 2; id_rt = 8; id_uses_rt = 0; id_regwen = 1; id_wsel = 10;
        #1 check("lu_no_rt", hazard_stall, 0);
        id_uses_rt = 1;
        #1 check("lu_hazard", hazard_stall, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_count", stall_count, 1);
        check("lu_one_cycle", hazard_stall, 0);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_wsel", ex_wsel, 10);
        clr_id();

        // hold with WB refresh of rt=9
        id_valid = 1; id_rt = 9; id_rdat2 = 32'h5; id_wsel = 12;
        tick();
        clr_id(); id_valid = 1; id_rt = 1; id_rdat2 = 32'h99; id_wsel = 13;
        ex_stall = 1;
        wb_regwen = 1; wb_wsel = 9; wb_wdat = 32'h77;
        tick();
        wb_regwen = 0;
        tick();
        ex_stall = 0;
        #1 check("hold_b", alu_b, 32'h77);
        check("hold_store", ex_store_dat, 32'h77);
        check("hold_wsel", ex_wsel, 12);
        clr_id();

        // flush beats stall and hazard
        id_valid = 1; id_memread = 1; id_regwen = 1; id_wsel = 8;
        tick();
        clr_id(); id_valid = 1; id_rs = 8;
        flush = 1; ex_stall = 1;
        #1 check("fl_hazard", hazard_stall, 0);
        tick();
        check("fl_valid", ex_valid, 0);
        check("fl_count", stall_count, 1);
        flush = 0; ex_stall = 0;
        clr_id();

        // saturation of a 2-bit counter: 1 + 3 hazards stops at 3
        for (int i = 0; i < 3; i++) load_use(5'd8);
        check("sat_count", stall_count, 3);

        // async reset between edges
        id_valid = 1; id_rs = 3; id_rdat1 = 32'h33;
        tick();
        check("pre_rst_valid", ex_valid, 1);
        #2 nRST = 0;
        #1 check("arst_valid", ex_valid, 0);
        check("arst_count", stall_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
